// File: rtl/instr_fetch_mem_pkg.sv
// Shared ISA constants for the fetch stage: opcode/register encodings, the
// NOP bubble word and the CLEAR/RUN state encoding.
package instr_fetch_mem_pkg;

    localparam int OPC_W = 7;
    localparam int REG_W = 5;
    localparam int IMM_W = 15;

    typedef enum logic [OPC_W-1:0] {
        NOP = 7'h00,
        ADD = 7'h01,
        ADI = 7'h02,
        LDW = 7'h03,
        STW = 7'h04,
        BEQ = 7'h05,
        JMP = 7'h06
    } opcode_e;

    typedef enum logic [REG_W-1:0] {
        R0 = 5'd0, R1 = 5'd1, R2 = 5'd2, R3 = 5'd3,
        R4 = 5'd4, R5 = 5'd5, R6 = 5'd6, R7 = 5'd7
    } reg_e;

    localparam logic [31:0] ISA_NOP_WORD = {NOP, R0, R0, 15'd0};

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } fetch_state_e;

    function automatic logic [31:0] mk_instr(opcode_e op, reg_e rd, reg_e rs,
                                             logic [IMM_W-1:0] imm);
        return {op, rd, rs, imm};
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-clock instruction RAM: one write port shared by boot clear and program
// load, one registered read port that holds its data when not enabled.
module imem_ram #(
    parameter int                ADDR_W = 14,
    parameter int                DEPTH  = 16384,
    parameter int                DATA_W = 32,
    parameter logic [DATA_W-1:0] FILL   = '0
) (
    input  logic              clk,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int              IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ok;
    logic              rd_ok;

    always_comb begin
        wr_en   = ld_en;
        wr_addr = ld_addr;
        wr_data = ld_data;
        if (clr_en) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
            wr_data = FILL;
        end
    end

    // Range guard keeps out-of-range addresses from aliasing onto low words.
    assign wr_ok = {1'b0, wr_addr} < LIMIT;
    assign rd_ok = {1'b0, rd_addr} < LIMIT;

    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) mem[wr_addr[IDX_W-1:0]] <= wr_data;
        if (rd_en && rd_ok) rd_data_q <= mem[rd_addr[IDX_W-1:0]];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: boot-time clear to NOP, program load port, and a
// one-cycle fetch into IR with stall/flush control and range checking.
module instr_fetch_mem
    import instr_fetch_mem_pkg::*;
#(
    parameter int                ADDR_W   = 14,
    parameter int                DEPTH    = 16384,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(ISA_NOP_WORD)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] PC,
    input  logic              fetch_req,
    output logic              fetch_rdy,
    input  logic              stall,
    input  logic              flush,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] IR,
    output logic              IR_valid,
    output logic              addr_err,
    output logic              init_done
);

    localparam logic [ADDR_W:0]   LIMIT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              ir_valid_q, ir_valid_d;
    logic              use_ram_q, use_ram_d;
    logic              addr_err_q, addr_err_d;
    logic [DATA_W-1:0] ram_rdata;
    logic              accept;
    logic              pc_oob;
    logic              ld_oob;

    assign fetch_rdy = (state_q == RUN) && !stall && !ld_en;
    assign init_done = (state_q == RUN);
    assign accept    = fetch_req && fetch_rdy;
    assign pc_oob    = {1'b0, PC} >= LIMIT;
    assign ld_oob    = {1'b0, ld_addr} >= LIMIT;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        use_ram_d  = use_ram_q;
        addr_err_d = 1'b0;

        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: if (ld_en && ld_oob) addr_err_d = 1'b1;
            default: state_d = CLEAR;
        endcase

        // IR is either the RAM's read register (in-range hit) or ir_q.
        if (flush) begin
            ir_d       = NOP_WORD;
            ir_valid_d = 1'b0;
            use_ram_d  = 1'b0;
        end else if (stall) begin
            ir_d = ir_q;
        end else if (accept) begin
            ir_d       = NOP_WORD;
            ir_valid_d = 1'b1;
            use_ram_d  = !pc_oob;
            if (pc_oob) addr_err_d = 1'b1;
        end else begin
            ir_d       = NOP_WORD;
            ir_valid_d = 1'b0;
            use_ram_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            ir_q       <= NOP_WORD;
            ir_valid_q <= 1'b0;
            use_ram_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            use_ram_q  <= use_ram_d;
            addr_err_q <= addr_err_d;
        end
    end

    imem_ram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .FILL   (NOP_WORD)
    ) u_ram (
        .clk      (clk),
        .clr_en   (state_q == CLEAR),
        .clr_addr (cnt_q),
        .ld_en    (ld_en && rst_n && (state_q == RUN)),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .rd_en    (accept && !flush),
        .rd_addr  (PC),
        .rd_data  (ram_rdata)
    );

    assign IR       = use_ram_q ? ram_rdata : ir_q;
    assign IR_valid = ir_valid_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Scoreboard bench for instr_fetch_mem with a 16-word memory.
module tb_instr_fetch_mem;
    import instr_fetch_mem_pkg::*;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 16;
    localparam int DATA_W = 32;

    typedef struct {
        logic [DATA_W-1:0] ir;
        logic              vld;
        logic              err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] PC;
    logic              fetch_req;
    logic              fetch_rdy;
    logic              stall;
    logic              flush;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] IR;
    logic              IR_valid;
    logic              addr_err;
    logic              init_done;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    logic [DATA_W-1:0] nop_w;
    logic [DATA_W-1:0] w4;
    logic [DATA_W-1:0] w7;

    instr_fetch_mem #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .PC        (PC),
        .fetch_req (fetch_req),
        .fetch_rdy (fetch_rdy),
        .stall     (stall),
        .flush     (flush),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .IR        (IR),
        .IR_valid  (IR_valid),
        .addr_err  (addr_err),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pop one expected IR result after the edge and compare all three outputs.
    task automatic pop_chk(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_ir"},  IR,                    e.ir);
            chk({tag, "_vld"}, {31'd0, IR_valid},     {31'd0, e.vld});
            chk({tag, "_err"}, {31'd0, addr_err},     {31'd0, e.err});
        end
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] ir,
                         input logic v, input logic err, input string tag);
        PC        = a;
        fetch_req = 1'b1;
        sb.push_back('{ir: ir, vld: v, err: err});
        step();
        fetch_req = 1'b0;
        pop_chk(tag);
    endtask

    task automatic load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        #1;
        chk("ld_rdy_low", {31'd0, fetch_rdy}, 32'd0);
        step();
        ld_en = 1'b0;
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (!init_done && n < 200) begin
            step();
            n++;
        end
        chk(tag, n, DEPTH);
    endtask

    initial begin
        nop_w = ISA_NOP_WORD;
        w4    = mk_instr(ADI, R6, R6, 15'd15);
        w7    = mk_instr(ADD, R1, R2, 15'd3);
        rst_n = 1'b0; PC = '0; fetch_req = 1'b0; stall = 1'b0; flush = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        step();
        step();
        chk("rst_ir",   IR, nop_w);
        chk("rst_vld",  {31'd0, IR_valid},  32'd0);
        chk("rst_err",  {31'd0, addr_err},  32'd0);
        chk("rst_init", {31'd0, init_done}, 32'd0);
        chk("rst_rdy",  {31'd0, fetch_rdy}, 32'd0);

        rst_n = 1'b1;
        wait_init("clear_cycles");

        for (int a = 0; a < DEPTH; a++) fetch(ADDR_W'(a), nop_w, 1'b1, 1'b0, "boot_nop");
        step();
        chk("bubble_vld", {31'd0, IR_valid}, 32'd0);
        chk("bubble_ir",  IR, nop_w);

        load(6'd4, w4);
        load(6'd7, w7);
        fetch(6'd4, w4, 1'b1, 1'b0, "ld_fetch4");
        fetch(6'd7, w7, 1'b1, 1'b0, "ld_fetch7");

        // Stall three cycles with a competing request that must be ignored.
        fetch(6'd4, w4, 1'b1, 1'b0, "pre_stall");
        stall = 1'b1; fetch_req = 1'b1; PC = 6'd7;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_rdy", {31'd0, fetch_rdy}, 32'd0);
            sb.push_back('{ir: w4, vld: 1'b1, err: 1'b0});
            step();
            pop_chk("stall_hold");
        end
        stall = 1'b0; fetch_req = 1'b0;

        flush = 1'b1;
        fetch(6'd7, nop_w, 1'b0, 1'b0, "flush_fetch");
        flush = 1'b0;
        fetch(6'd7, w7, 1'b1, 1'b0, "post_flush");
        stall = 1'b1; flush = 1'b1;
        sb.push_back('{ir: nop_w, vld: 1'b0, err: 1'b0});
        step();
        pop_chk("flush_over_stall");
        stall = 1'b0; flush = 1'b0;

        fetch(6'd20, nop_w, 1'b1, 1'b1, "oob_fetch");
        step();
        chk("oob_err_pulse", {31'd0, addr_err}, 32'd0);

        load(6'd20, 32'hdead_beef);
        chk("ld_oob_err", {31'd0, addr_err}, 32'd1);
        step();
        chk("ld_oob_err_end", {31'd0, addr_err}, 32'd0);
        fetch(6'd4, w4, 1'b1, 1'b0, "no_alias");

        rst_n = 1'b0;
        step();
        chk("rerst_init", {31'd0, init_done}, 32'd0);
        chk("rerst_vld",  {31'd0, IR_valid},  32'd0);
        rst_n = 1'b1;
        wait_init("reclear_cycles");
        fetch(6'd4, nop_w, 1'b1, 1'b0, "reclear_fetch4");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 14: PC width in words.
REQ-002 SHALL have parameter DEPTH, default 16384: number of stored words, at most 2^ADDR_W.
REQ-003 SHALL have parameter DATA_W, default 32: instruction word width.
REQ-004 SHALL have parameter NOP_WORD, default {NOP,R0,R0,15'd0} (from shared package): fill and bubble value.
REQ-005 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port PC, input, ADDR_W: fetch word address.
REQ-008 SHALL have port fetch_req, input, 1: fetch request.
REQ-009 SHALL have port fetch_rdy, output, 1: fetch can be accepted this cycle.
REQ-010 SHALL have port stall, input, 1: hold IR and IR_valid.
REQ-011 SHALL have port flush, input, 1: replace the in-flight or held instruction with a bubble.
REQ-012 SHALL have port ld_en, input, 1: program-load write strobe.
REQ-013 SHALL have port ld_addr, input, ADDR_W: load address.
REQ-014 SHALL have port ld_data, input, DATA_W: load data.
REQ-015 SHALL have port IR, output, DATA_W: registered instruction.
REQ-016 SHALL have port IR_valid, output, 1: IR holds a fetched instruction.
REQ-017 SHALL have port addr_err, output, 1: one-cycle pulse on an out-of-range access.
REQ-018 SHALL have port init_done, output, 1: boot clear complete.

Function
REQ-019 SHALL implement FSM states CLEAR and RUN; reset enters CLEAR with clear counter 0.
REQ-020 SHALL in CLEAR write NOP_WORD to word [counter] each cycle, incrementing; after word DEPTH-1 is written, enter RUN next cycle; clear takes exactly DEPTH cycles.
REQ-021 SHALL hold init_done=0 and fetch_rdy=0 in CLEAR, and ignore ld_en in CLEAR.
REQ-022 SHALL in RUN drive fetch_rdy = !stall && !ld_en.
REQ-023 SHALL accept a fetch when fetch_req && fetch_rdy; on the next cycle IR = mem[PC sampled at acceptance] and IR_valid=1 (latency 1).
REQ-024 SHALL, for a cycle with no accepted fetch and no stall, load IR=NOP_WORD and IR_valid=0 on the next edge.
REQ-025 SHALL, while stall=1, hold IR and IR_valid unchanged; fetch_req is ignored.
REQ-026 SHALL, when flush=1, load IR=NOP_WORD and IR_valid=0 on the next edge; flush overrides both stall and an accepted fetch (the accepted fetch is dropped).
REQ-027 SHALL, when ld_en=1 in RUN with ld_addr < DEPTH, write ld_data to mem[ld_addr] on that edge; the written value is visible to a fetch accepted on any later cycle.
REQ-028 SHALL, for an accepted fetch with PC >= DEPTH, return IR=NOP_WORD with IR_valid=1 and pulse addr_err for one cycle, aligned with IR.
REQ-029 SHALL, for ld_en with ld_addr >= DEPTH, discard the write and pulse addr_err on the next cycle.
REQ-030 SHALL never wrap addresses: out-of-range accesses never alias to an in-range word.

Reset
REQ-031 SHALL, while rst_n=0 at an edge: state=CLEAR, counter=0, IR=NOP_WORD, IR_valid=0, addr_err=0, init_done=0, fetch_rdy=0.
REQ-032 SHALL on reset mid-RUN or mid-CLEAR abandon all in-flight work and restart the full clear; previously loaded contents are lost.

Structure
REQ-033 SHALL take opcode/register constants, NOP_WORD and the CLEAR/RUN state encoding from the shared ISA package used by the assembler parameters.
REQ-034 SHALL instantiate one sub-module, imem_ram: a single-clock RAM with one write port and one registered read port, parametrised by ADDR_W/DATA_W/DEPTH.
REQ-035 SHALL, in imem_ram, mux the write port between the clear counter (CLEAR) and the load port (RUN).

Verification
REQ-036 SHALL cover: DEPTH=16 reset -> init_done rises exactly 16 cycles after rst_n goes high; fetch of every address returns NOP_WORD.
REQ-037 SHALL cover: load mem[4]={ADI,R6,R6,15'd15}, then fetch PC=4 -> next cycle IR equals that word and IR_valid=1.
REQ-038 SHALL cover: fetch PC=4 with stall held 3 cycles -> IR unchanged for 3 cycles and fetch_rdy=0 throughout.
REQ-039 SHALL cover: accepted fetch with flush in the same cycle -> IR=NOP_WORD and IR_valid=0.
REQ-040 SHALL cover: DEPTH=16, fetch PC=20 -> IR=NOP_WORD, IR_valid=1, addr_err single-cycle pulse; load to ld_addr=20 -> no write and an addr_err pulse.
REQ-041 SHALL cover: rst_n low for one cycle mid-RUN after loads -> CLEAR re-entered, and after DEPTH cycles mem[4] reads NOP_WORD.
